psram_responder: RTL

PSRAM_RESPONDER -- requirements
Module: psram_responder

---
 rtl/psram_pkg.sv | 54 +++++
 rtl/psram_resp_mem.sv | 36 +++
 rtl/psram_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// psram_pkg: shared types, widths and timing constants for the PSRAM
// responder model (state encoding, command capture record, busy-length and
// byte-lane helpers).
package psram_pkg;

    localparam int WORD_W  = 16;
    localparam int BYTE_W  = 8;
    localparam int ADDR_W  = 22;
    localparam int CNT_W   = 24;

    // Fixed part of the busy window; the latency part is added per command.
    localparam int WR_BASE = 3;
    localparam int RD_BASE = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bit 0 enables lane [7:0], bit 1 enables lane [15:8].
    typedef logic [1:0] lane_t;

    // Everything about a command that must survive later input changes.
    typedef struct packed {
        logic              is_read;
        lane_t             lanes;
        logic [WORD_W-1:0] data;
    } cmd_t;

    // Number of cycles busy stays high for one command.
    function automatic int busy_cycles(input logic is_read, input logic is_2x,
                                       input int latency);
        return (is_read ? RD_BASE : WR_BASE) + (is_2x ? 2 * latency : latency);
    endfunction

    // Lane enables for a write: both lanes for a word write, otherwise the
    // lane selected by the byte address bit.
    function automatic lane_t lane_mask(input logic byte_write, input logic lsb);
        if (!byte_write) begin
            return 2'b11;
        end
        return lsb ? 2'b10 : 2'b01;
    endfunction

    // Increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// psram_resp_mem: 2^DEPTH_BITS x 16 single-port block RAM with independent
// byte-lane write enables and a registered read port.
module psram_resp_mem
    import psram_pkg::*;
#(
    parameter int DEPTH_BITS = 12
) (
    input  logic                  clk,
    input  logic [DEPTH_BITS-1:0] addr,
    input  logic [1:0]            we,
    input  logic [WORD_W-1:0]     wdata,
    input  logic                  rd_en,
    output logic [WORD_W-1:0]     rdata
);

    localparam int WORDS = 1 << DEPTH_BITS;

    logic [WORD_W-1:0] mem [0:WORDS-1];

    // Lane-masked write and registered read on the shared address.
    // NOTE: the array and read register have no reset on purpose; a reset
    // branch would stop this mapping onto block RAM and would also wipe the
    // contents, which must survive a reset.
    always_ff @(posedge clk) begin
        if (we[0]) begin
            mem[addr][BYTE_W-1:0] <= wdata[BYTE_W-1:0];
        end
        if (we[1]) begin
            mem[addr][WORD_W-1:BYTE_W] <= wdata[WORD_W-1:BYTE_W];
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/psram_responder.sv
// psram_responder: cycle-level behavioural PSRAM device. Commands are
// accepted in IDLE/DONE, held busy for a latency-dependent window (doubled
// when a refresh is pending), and complete on the cycle busy falls.
// Optional statistics counters: define PSRAM_RESP_STATS_EN to make cnt_1x /
// cnt_2x live; otherwise both read as zero and no counters exist.
module psram_responder
    import psram_pkg::*;
#(
    parameter int LATENCY        = 3,
    parameter int INIT_CYCLES    = 32,
    parameter int DEPTH_BITS     = 12,
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic              byte_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              busy,
    output logic              proto_err,
    output logic [CNT_W-1:0]  cnt_1x,
    output logic [CNT_W-1:0]  cnt_2x
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int WAIT_W = $clog2(RD_BASE + 2 * LATENCY + 1);
    localparam int REF_W  = $clog2(REFRESH_CYCLES + 1);

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

    state_t                state;
    logic [INIT_W-1:0]     init_cnt;
    logic [WAIT_W-1:0]     remaining;
    cmd_t                  cmd_q;
    logic [DEPTH_BITS-1:0] word_q;

    logic [REF_W-1:0]      ref_cnt;
    logic                  refresh_pending;
    logic                  refresh_tick;

    logic                  cmd_ok;
    logic                  accept;
    logic                  cmd_err;
    logic                  is_2x;
    logic                  next_is_read;
    logic                  done_evt;
    logic                  mem_rd_en;
    logic [1:0]            mem_we;
    logic [WORD_W-1:0]     mem_rdata;

    // Address bits above the backed depth alias and are deliberately dropped.
    logic                  addr_unused;
    assign addr_unused = ^addr[ADDR_W-1:DEPTH_BITS+1];

    // Command acceptance and protocol-violation detection.
    assign cmd_ok       = (state == ST_IDLE) || (state == ST_DONE);
    assign accept       = cmd_ok && (read || write);
    assign cmd_err      = (!cmd_ok && (read || write)) || (cmd_ok && read && write);
    assign next_is_read = read && !write;

    // A tick landing on the acceptance cycle counts as pending for that command.
    assign refresh_tick = (ref_cnt == REF_LAST);
    assign is_2x        = refresh_pending || refresh_tick;

    // Last cycle of the busy window: memory update and dout capture happen here.
    assign done_evt  = (state == ST_WAIT) && (remaining == '0);
    // Read is launched one cycle early so the registered RAM output is ready
    // on the completion cycle.
    assign mem_rd_en = (state == ST_WAIT) && cmd_q.is_read && (remaining == WAIT_W'(1));
    // Reset on the completion cycle aborts the write.
    assign mem_we    = (done_evt && !cmd_q.is_read && !reset) ? cmd_q.lanes : 2'b00;

    // Free-running refresh timer and the pending flag it raises.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt         <= '0;
            refresh_pending <= 1'b0;
        end else begin
            ref_cnt <= refresh_tick ? '0 : ref_cnt + 1'b1;
            if (accept) begin
                refresh_pending <= 1'b0;
            end else if (refresh_tick) begin
                refresh_pending <= 1'b1;
            end
        end
    end

    // Main controller: INIT -> IDLE -> WAIT -> DONE with registered outputs.
    // NOTE: every register here is written with <= so that all branches see
    // the pre-edge values of state, counters and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            busy      <= 1'b1;
            dout      <= '0;
            proto_err <= 1'b0;
            init_cnt  <= '0;
            remaining <= '0;
            cmd_q     <= '0;
            word_q    <= '0;
        end else begin
            if (cmd_err) begin
                proto_err <= 1'b1;
            end

            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end

                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        state         <= ST_WAIT;
                        busy          <= 1'b1;
                        cmd_q.is_read <= next_is_read;
                        cmd_q.lanes   <= lane_mask(byte_write, addr[0]);
                        cmd_q.data    <= din;
                        word_q        <= addr[DEPTH_BITS:1];
                        remaining     <= WAIT_W'(busy_cycles(next_is_read, is_2x, LATENCY) - 1);
                    end
                end

                ST_WAIT: begin
                    if (remaining == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        if (cmd_q.is_read) begin
                            dout <= mem_rdata;
                        end
                    end else begin
                        remaining <= remaining - 1'b1;
                    end
                end

                default: begin
                    state <= ST_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PSRAM_RESP_STATS_EN
    logic             run_2x;
    logic [CNT_W-1:0] cnt_1x_q;
    logic [CNT_W-1:0] cnt_2x_q;

    // Saturating completion counters, split by the command's latency mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_2x   <= 1'b0;
            cnt_1x_q <= '0;
            cnt_2x_q <= '0;
        end else begin
            if (accept) begin
                run_2x <= is_2x;
            end
            if (done_evt) begin
                if (run_2x) begin
                    cnt_2x_q <= sat_inc(cnt_2x_q);
                end else begin
                    cnt_1x_q <= sat_inc(cnt_1x_q);
                end
            end
        end
    end

    assign cnt_1x = cnt_1x_q;
    assign cnt_2x = cnt_2x_q;
`else
    assign cnt_1x = '0;
    assign cnt_2x = '0;
`endif

    psram_resp_mem #(
        .DEPTH_BITS(DEPTH_BITS)
    ) u_mem (
        .clk   (clk),
        .addr  (word_q),
        .we    (mem_we),
        .wdata (cmd_q.data),
        .rd_en (mem_rd_en),
        .rdata (mem_rdata)
    );

endmodule
